// File: rtl/icache_stage.sv
// icache_stage: direct-mapped instruction cache between the fetch stage and
// main memory. 2^INDEX_BITS lines of 16 bytes each.
//
// Ports:
//   clk, reset       single clock; synchronous active-high reset
//   req_valid        fetch presents a valid instruction address
//   req_addr[15:0]   instruction byte address (bit 0 ignored)
//   flush            invalidate every line
//   inst_code_high   byte at {req_addr[15:1],0}; 0x00 when not hit
//   inst_code_low    byte at {req_addr[15:1],1}; 0x00 when not hit
//   hit              instruction bytes valid this cycle
//   stall            fetch must hold req_addr and not advance the PC
//   mem_req          one-cycle line-read request to memory
//   mem_addr[15:0]   line-aligned refill address
//   mem_valid        memory returns the requested line
//   mem_data[127:0]  line data, byte k at [8k+7:8k]
module icache_stage #(
  parameter int INDEX_BITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [15:0]  req_addr,
  input  logic         flush,
  output logic [7:0]   inst_code_high,
  output logic [7:0]   inst_code_low,
  output logic         hit,
  output logic         stall,
  output logic         mem_req,
  output logic [15:0]  mem_addr,
  input  logic         mem_valid,
  input  logic [127:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 12 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [127:0]          r_data [LINES];
  logic [15:0]           r_miss_line;

  logic [INDEX_BITS-1:0] w_index;
  logic [INDEX_BITS-1:0] w_miss_index;
  logic [TAG_W-1:0]      w_tag;
  logic [TAG_W-1:0]      w_miss_tag;
  logic [127:0]          w_line;
  logic [6:0]            w_hi_bit;
  logic [6:0]            w_lo_bit;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_latch;
  logic                  w_unused_addr0;

  assign w_index        = req_addr[3+INDEX_BITS:4];
  assign w_tag          = req_addr[15:4+INDEX_BITS];
  assign w_miss_index   = r_miss_line[3+INDEX_BITS:4];
  assign w_miss_tag     = r_miss_line[15:4+INDEX_BITS];
  assign w_line         = r_data[w_index];
  // Instructions are halfword aligned, so address bit 0 never selects data.
  assign w_unused_addr0 = req_addr[0];

  // Bit positions of byte (offset & ~1) and byte (offset | 1) in the line.
  assign w_hi_bit = {req_addr[3:1], 4'b0000};
  assign w_lo_bit = {req_addr[3:1], 4'b1000};

  assign w_hit  = (r_state == ST_IDLE) && req_valid && r_valid[w_index] &&
                  (r_tag[w_index] == w_tag);
  // Memory responses are only accepted while waiting for the refill.
  assign w_fill = (r_state == ST_WAIT) && mem_valid;

  always_comb begin
    w_state_next   = r_state;
    w_latch        = 1'b0;
    hit            = w_hit;
    stall          = req_valid && !w_hit;
    mem_req        = (r_state == ST_REQ);
    mem_addr       = r_miss_line;
    inst_code_high = 8'h00;
    inst_code_low  = 8'h00;
    if (w_hit) begin
      inst_code_high = w_line[w_hi_bit +: 8];
      inst_code_low  = w_line[w_lo_bit +: 8];
    end
    case (r_state)
      ST_IDLE: begin
        if (req_valid && !w_hit) begin
          w_state_next = ST_REQ;
          w_latch      = 1'b1;
        end
      end
      ST_REQ:  w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state: FSM, valid bits, pending miss line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_valid     <= '0;
      r_miss_line <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_latch) r_miss_line <= {req_addr[15:4], 4'b0000};
      // A refill landing with a flush still ends valid: the set wins.
      if (flush)  r_valid <= '0;
      if (w_fill) r_valid[w_miss_index] <= 1'b1;
    end
  end

  // Line storage: tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (w_fill && !reset) begin
      r_tag[w_miss_index]  <= w_miss_tag;
      r_data[w_miss_index] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_stage.sv
module tb_icache_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [15:0]  req_addr;
  logic         flush;
  logic [7:0]   inst_code_high;
  logic [7:0]   inst_code_low;
  logic         hit;
  logic         stall;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic         mem_valid;
  logic [127:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  icache_stage #(.INDEX_BITS(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .inst_code_high(inst_code_high), .inst_code_low(inst_code_low),
    .hit(hit), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory image: byte k of the line at address A is A[7:0] + k.
  function automatic logic [127:0] mk_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = a[7:0] + 8'(k);
    return l;
  endfunction

  // Drives a miss on addr and answers the refill after 'delay' WAIT cycles.
  // flush_at selects the WAIT cycle (0..delay) carrying flush; -1 for none.
  task automatic refill(input logic [15:0] addr, input int delay, input int flush_at,
                        output logic [15:0] seen, output int stalls, output bit got_req);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; mem_valid = 1'b0; flush = 1'b0;
    stalls = 0; got_req = 1'b0; seen = 16'hxxxx;
    for (int i = 0; i < 8 && !got_req; i++) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin got_req = 1'b1; seen = mem_addr; end
      @(negedge clk);
    end
    if (got_req) begin
      for (int i = 0; i < delay; i++) begin
        flush = (i == flush_at);
        #1;
        if (stall) stalls++;
        @(negedge clk);
      end
      flush = (delay == flush_at);
      mem_valid = 1'b1; mem_data = mk_line({addr[15:4], 4'h0});
      #1;
      if (stall) stalls++;
      @(negedge clk);
      mem_valid = 1'b0; flush = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = 16'h000C; flush = 1'b0;
    mem_valid = 1'b0; mem_data = '0;
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b expected 0", hit); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %0b expected 1", stall); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    req_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %0b expected 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h000C;
    #1;
    n_checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_c0: stall=%0b mem_req=%0b expected 1/0", stall, mem_req); end
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_c1: stall=%0b mem_req=%0b expected 1/1", stall, mem_req); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL cold_mem_addr: got %h expected 0000", mem_addr); end
    @(negedge clk);
    mem_valid = 1'b1; mem_data = mk_line(16'h0000);
    #1;
    n_checks++; if (stall !== 1'b1 || mem_req !== 1'b0 || hit !== 1'b0) begin n_fail++; $display("FAIL cold_c2: stall=%0b mem_req=%0b hit=%0b expected 1/0/0", stall, mem_req, hit); end
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    n_checks++; if (hit !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL cold_c3: hit=%0b stall=%0b expected 1/0", hit, stall); end
    n_checks++; if (inst_code_high !== 8'h0C || inst_code_low !== 8'h0D) begin n_fail++; $display("FAIL cold_bytes: got %h/%h expected 0c/0d", inst_code_high, inst_code_low); end
  endtask

  task automatic test_same_line_hit;
    @(negedge clk);
    req_addr = 16'h000E;
    #1;
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h0E || inst_code_low !== 8'h0F) begin n_fail++; $display("FAIL same_line_0e: hit=%0b bytes=%h/%h expected 1 0e/0f", hit, inst_code_high, inst_code_low); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL same_line_mem_req: got %0b expected 0", mem_req); end
    @(negedge clk);
    req_addr = 16'h0001;
    #1;
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h00 || inst_code_low !== 8'h01) begin n_fail++; $display("FAIL same_line_odd: hit=%0b bytes=%h/%h expected 1 00/01", hit, inst_code_high, inst_code_low); end
    @(negedge clk); #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL same_line_no_req: got %0b expected 0", mem_req); end
  endtask

  task automatic test_conflict;
    logic [15:0] seen; int stalls; bit got;
    refill(16'h0040, 0, -1, seen, stalls, got);
    n_checks++; if (!got || seen !== 16'h0040) begin n_fail++; $display("FAIL conflict_addr40: req=%0b addr=%h expected 1 0040", got, seen); end
    n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL conflict_penalty: got %0d stall cycles expected 3", stalls); end
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h40 || inst_code_low !== 8'h41) begin n_fail++; $display("FAIL conflict_hit40: hit=%0b bytes=%h/%h expected 1 40/41", hit, inst_code_high, inst_code_low); end
    refill(16'h0002, 0, -1, seen, stalls, got);
    n_checks++; if (!got || seen !== 16'h0000) begin n_fail++; $display("FAIL conflict_addr00: req=%0b addr=%h expected 1 0000", got, seen); end
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h02 || inst_code_low !== 8'h03) begin n_fail++; $display("FAIL conflict_hit02: hit=%0b bytes=%h/%h expected 1 02/03", hit, inst_code_high, inst_code_low); end
  endtask

  task automatic test_flush_wait;
    logic [15:0] seen; int stalls; bit got;
    refill(16'h0010, 0, -1, seen, stalls, got);
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h10 || inst_code_low !== 8'h11) begin n_fail++; $display("FAIL flush_fill10: hit=%0b bytes=%h/%h expected 1 10/11", hit, inst_code_high, inst_code_low); end
    refill(16'h0024, 10, 3, seen, stalls, got);
    n_checks++; if (!got || seen !== 16'h0020) begin n_fail++; $display("FAIL flush_addr20: req=%0b addr=%h expected 1 0020", got, seen); end
    n_checks++; if (stalls !== 13) begin n_fail++; $display("FAIL flush_slow_stall: got %0d stall cycles expected 13", stalls); end
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h24 || inst_code_low !== 8'h25) begin n_fail++; $display("FAIL flush_hit24: hit=%0b bytes=%h/%h expected 1 24/25", hit, inst_code_high, inst_code_low); end
    req_addr = 16'h0010;
    #1;
    n_checks++; if (hit !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL flush_miss10: hit=%0b stall=%0b expected 0/1", hit, stall); end
    req_valid = 1'b0;
    // Flush in the same cycle as mem_valid: only the refilled line survives.
    refill(16'h0010, 0, -1, seen, stalls, got);
    refill(16'h0036, 0, 0, seen, stalls, got);
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h36 || inst_code_low !== 8'h37) begin n_fail++; $display("FAIL flush_same_cycle_hit: hit=%0b bytes=%h/%h expected 1 36/37", hit, inst_code_high, inst_code_low); end
    req_addr = 16'h0010;
    #1;
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle_other: hit=%0b expected 0", hit); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h000C;
    @(negedge clk); #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_req: got %0b expected 1", mem_req); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; mem_valid = 1'b1; mem_data = mk_line(16'h0000);
    #1;
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: mem_req=%0b stall=%0b expected 0/0", mem_req, stall); end
    @(negedge clk);
    mem_valid = 1'b0; req_valid = 1'b1; req_addr = 16'h000C;
    #1;
    n_checks++; if (hit !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL rstw_late_ignored: hit=%0b stall=%0b expected 0/1", hit, stall); end
    @(negedge clk);
    // mem_valid in the REQ cycle must be ignored.
    mem_valid = 1'b1; mem_data = mk_line(16'h0080);
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rstw_new_req: mem_req=%0b addr=%h expected 1 0000", mem_req, mem_addr); end
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1 || hit !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_req_valid_ignored: stall=%0b hit=%0b mem_req=%0b expected 1/0/0", stall, hit, mem_req); end
    @(negedge clk);
    mem_valid = 1'b1; mem_data = mk_line(16'h0000);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    n_checks++; if (hit !== 1'b1 || inst_code_high !== 8'h0C || inst_code_low !== 8'h0D) begin n_fail++; $display("FAIL rstw_refill: hit=%0b bytes=%h/%h expected 1 0c/0d", hit, inst_code_high, inst_code_low); end
  endtask

  task automatic test_no_request;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'h000C;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if (hit !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || inst_code_high !== 8'h00 || inst_code_low !== 8'h00) begin
        n_fail++;
        $display("FAIL no_request cycle %0d: hit=%0b stall=%0b mem_req=%0b bytes=%h/%h expected 0/0/0 00/00", i, hit, stall, mem_req, inst_code_high, inst_code_low);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line_hit();
    test_conflict();
    test_flush_wait();
    test_reset_wait();
    test_no_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
